// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
//
// Shared definitions for the 16-bit RISC core front end:
//   - instruction opcode constants and field bit positions
//   - fetch/decode FSM state encoding
//   - ALU opcode type (also used by the ALU)
//   - decoded-control record produced by risc_instr_decoder
//   - immediate extension helper
// -----------------------------------------------------------------------------
package risc_pkg;

  // Instruction field bit positions: [15:12] opcode, [11:8] rd,
  // [7:4] rs1, [3:0] rs2/imm4.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  // Opcode constants. 0xB..0xE are NOPs and have no named constant; they
  // fall through to the decoder default.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Fetch/decode controller states.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  // ALU operation codes. The register-register ops keep the same numbering
  // as their instruction opcodes; PASSB forwards operand B (used by LDI).
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SHL   = 4'd5,
    ALU_SHR   = 4'd6,
    ALU_PASSB = 4'd7
  } alu_op_e;

  // Which instruction bits form the immediate.
  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_ZEXT4 = 2'd1,
    IMM_ZEXT8 = 2'd2
  } imm_sel_e;

  // Control record for one instruction.
  typedef struct packed {
    logic     writes_rd;
    logic     use_imm;
    imm_sel_e imm_sel;
    logic     is_branch;
    logic     is_jump;
    logic     is_halt;
    alu_op_e  alu_op;
  } dec_t;

  // Build the 16-bit immediate for the selected encoding.
  function automatic logic [15:0] extend_imm(input imm_sel_e sel,
                                             input logic [15:0] instr);
    logic [15:0] value;
    value = '0;
    case (sel)
      IMM_ZEXT4: value = {12'h000, instr[RS2_HI:RS2_LO]};
      IMM_ZEXT8: value = {8'h00, instr[RS1_HI:RS2_LO]};
      default:   value = '0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/risc_instr_decoder.sv
// -----------------------------------------------------------------------------
// risc_instr_decoder
//
// Purely combinational opcode decoder.
//   opcode  in   4          instruction bits [15:12]
//   dec     out  dec_t      {writes_rd, use_imm, imm_sel, is_branch,
//                            is_jump, is_halt, alu_op}
// Anything not listed (0xB..0xE) decodes as a NOP: every flag clear.
// -----------------------------------------------------------------------------
module risc_instr_decoder
  import risc_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so that no opcode
    // path leaves a field unassigned, which would infer a latch.
    dec           = '0;
    dec.imm_sel   = IMM_NONE;
    dec.alu_op    = ALU_ADD;

    case (opcode)
      OP_ADD: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_SUB: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      OP_AND: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_AND;
      end
      OP_OR: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_OR;
      end
      OP_XOR: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_XOR;
      end
      OP_SHL: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_SHL;
      end
      OP_SHR: begin
        dec.writes_rd = 1'b1;
        dec.alu_op    = ALU_SHR;
      end
      OP_ADDI: begin
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm_sel   = IMM_ZEXT4;
        dec.alu_op    = ALU_ADD;
      end
      OP_LDI: begin
        // The ALU forwards the 8-bit immediate unchanged.
        dec.writes_rd = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm_sel   = IMM_ZEXT8;
        dec.alu_op    = ALU_PASSB;
      end
      OP_BEQ: begin
        // Equality is tested by subtracting and looking at alu_zero.
        dec.is_branch = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      OP_JMP:  dec.is_jump = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_fetch_decode.sv
// -----------------------------------------------------------------------------
// risc_fetch_decode
//
// Multi-cycle fetch/decode controller for the 16-bit RISC core. Holds the
// PC, fetches instructions over a req/ack port, decodes them and drives the
// register file and ALU controls; resolves BEQ, JMP and HALT.
//
// Parameters
//   PC_W         program-counter / instruction-address width (5..16)
// Ports
//   clk          in   1     rising-edge clock
//   reset        in   1     asynchronous, active-high
//   run          in   1     leave IDLE and start fetching at PC 0
//   imem_req     out  1     high throughout FETCH
//   imem_addr    out  PC_W  fetch address (= pc)
//   imem_ack     in   1     instruction valid; honoured only in FETCH
//   imem_rdata   in   16    instruction word
//   alu_zero     in   1     ALU result == 0, sampled at end of EXECUTE
//   rf_r1/rf_r2  out  4     register-file read addresses (rs1, rs2)
//   rf_w1        out  4     register-file write address (rd)
//   rf_wen       out  1     register-file write enable (WRITEBACK only)
//   alu_op       out  4     ALU operation (alu_op_e)
//   alu_use_imm  out  1     ALU operand B is imm
//   imm          out  16    extended immediate
//   pc           out  PC_W  current PC
//   halted       out  1     HALT executed
//
// Per-instruction cycle counts with a zero-wait fetch:
//   ALU/ADDI/LDI  FETCH DECODE EXECUTE WRITEBACK   (4)
//   BEQ           FETCH DECODE EXECUTE             (3)
//   JMP/NOP       FETCH DECODE                     (2)
// -----------------------------------------------------------------------------
module risc_fetch_decode
  import risc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            alu_zero,
  output logic [3:0]      rf_r1,
  output logic [3:0]      rf_r2,
  output logic [3:0]      rf_w1,
  output logic            rf_wen,
  output logic [3:0]      alu_op,
  output logic            alu_use_imm,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_e          state;
  state_e          state_next;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     ir;          // instruction latched at the end of FETCH
  dec_t            dec;

  // ---------------------------------------------------------------------------
  // Decode of the latched instruction
  // ---------------------------------------------------------------------------
  risc_instr_decoder u_decoder (
    .opcode (ir[OPC_HI:OPC_LO]),
    .dec    (dec)
  );

  // ---------------------------------------------------------------------------
  // PC arithmetic; all sums wrap modulo 2^PC_W by truncation.
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  assign pc_inc     = pc_q + PC_W'(1);
  // The sized cast of a signed 4-bit value sign-extends the offset.
  assign br_off     = PC_W'($signed(ir[RD_HI:RD_LO]));
  assign br_target  = pc_inc + br_off;
  assign jmp_target = ir[PC_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state and next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pc_next    = pc_q;

    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) state_next = S_DECODE;
      end

      S_DECODE: begin
        if (dec.is_halt) begin
          state_next = S_HALT;
        end else if (dec.is_jump) begin
          pc_next    = jmp_target;
          state_next = S_FETCH;
        end else if (dec.writes_rd || dec.is_branch) begin
          state_next = S_EXECUTE;
        end else begin
          // NOP
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
      end

      S_EXECUTE: begin
        if (dec.is_branch) begin
          pc_next    = alu_zero ? br_target : pc_inc;
          state_next = S_FETCH;
        end else begin
          state_next = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        pc_next    = pc_inc;
        state_next = S_FETCH;
      end

      S_HALT: state_next = S_HALT;   // only reset leaves HALT

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, PC, instruction and decoded-output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      ir          <= '0;
      rf_r1       <= '0;
      rf_r2       <= '0;
      rf_w1       <= '0;
      alu_op      <= '0;
      alu_use_imm <= 1'b0;
      imm         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      state <= state_next;
      pc_q  <= pc_next;

      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
      end

      // Register-file and ALU controls change only on leaving DECODE and
      // hold until the next one. For BEQ, rf_w1 carries the offset field;
      // that is harmless because BEQ never reaches WRITEBACK.
      if (state == S_DECODE) begin
        rf_r1       <= ir[RS1_HI:RS1_LO];
        rf_r2       <= ir[RS2_HI:RS2_LO];
        rf_w1       <= ir[RD_HI:RD_LO];
        alu_op      <= dec.alu_op;
        alu_use_imm <= dec.use_imm;
        imm         <= extend_imm(dec.imm_sel, ir);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs. Driving these straight from the asynchronously
  // reset state register makes rf_wen drop the instant reset asserts.
  // ---------------------------------------------------------------------------
  assign imem_req  = (state == S_FETCH);
  assign rf_wen    = (state == S_WRITEBACK);
  assign halted    = (state == S_HALT);
  assign imem_addr = pc_q;   // pc only moves outside FETCH, so this is stable
  assign pc        = pc_q;

endmodule

// File: tb/tb_risc_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_risc_fetch_decode
//
// Directed bench for risc_fetch_decode. A small instruction memory answers
// imem_req after a programmable number of wait cycles. Outputs are sampled
// 1 ns after the rising edge.
//
// Program:
//   0x00 ADD  r1,r2,r3     0x0123
//   0x01 LDI  r5,0xA7      0x85A7
//   0x02 ADDI r4,r3,15     0x743F
//   0x03 NOP               0xB000
//   0x04 BEQ  r1,r2,-3     0x9D12   (taken -> 0x02, then not taken -> 0x05)
//   0x05 JMP  0xFF         0xA0FF
//   0xFF NOP               0xC000   (pc wraps to 0x00)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_risc_fetch_decode;

  localparam int PC_W = 8;

  logic            clk;
  logic            reset;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack   = 1'b0;
  logic [15:0]     imem_rdata = '0;
  logic            alu_zero;
  logic [3:0]      rf_r1;
  logic [3:0]      rf_r2;
  logic [3:0]      rf_w1;
  logic            rf_wen;
  logic [3:0]      alu_op;
  logic            alu_use_imm;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc;
  logic            halted;

  logic [15:0] mem [256];
  int          ack_wait = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  risc_fetch_decode #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .alu_zero    (alu_zero),
    .rf_r1       (rf_r1),
    .rf_r2       (rf_r2),
    .rf_w1       (rf_w1),
    .rf_wen      (rf_wen),
    .alu_op      (alu_op),
    .alu_use_imm (alu_use_imm),
    .imm         (imm),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: ack after ack_wait low cycles of an active request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt >= ack_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at 100 us, expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hB000;
    mem[8'h00] = 16'h0123;
    mem[8'h01] = 16'h85A7;
    mem[8'h02] = 16'h743F;
    mem[8'h03] = 16'hB000;
    mem[8'h04] = 16'h9D12;
    mem[8'h05] = 16'hA0FF;
    mem[8'hFF] = 16'hC000;

    reset    = 1'b1;
    run      = 1'b0;
    alu_zero = 1'b0;
    ticks(2);

    // ---- reset values ----
    check("rst_pc",      32'(pc), 0);
    check("rst_req",     32'(imem_req), 0);
    check("rst_addr",    32'(imem_addr), 0);
    check("rst_r1",      32'(rf_r1), 0);
    check("rst_r2",      32'(rf_r2), 0);
    check("rst_w1",      32'(rf_w1), 0);
    check("rst_wen",     32'(rf_wen), 0);
    check("rst_op",      32'(alu_op), 0);
    check("rst_use_imm", 32'(alu_use_imm), 0);
    check("rst_imm",     32'(imm), 0);
    check("rst_halted",  32'(halted), 0);

    reset = 1'b0;
    ticks(2);
    check("idle_wait_run", 32'(imem_req), 0);

    // ---- ADD r1,r2,r3 : 4 cycles ----
    run = 1'b1;
    tick();                                   // FETCH
    run = 1'b0;
    check("add_fetch_req",  32'(imem_req), 1);
    check("add_fetch_addr", 32'(imem_addr), 0);
    tick();                                   // DECODE
    check("add_dec_req",    32'(imem_req), 0);
    check("add_dec_wen",    32'(rf_wen), 0);
    tick();                                   // EXECUTE
    check("add_r1",         32'(rf_r1), 2);
    check("add_r2",         32'(rf_r2), 3);
    check("add_w1",         32'(rf_w1), 1);
    check("add_op",         32'(alu_op), 0);
    check("add_use_imm",    32'(alu_use_imm), 0);
    check("add_ex_wen",     32'(rf_wen), 0);
    tick();                                   // WRITEBACK
    check("add_wb_wen",     32'(rf_wen), 1);
    tick();                                   // FETCH @1
    check("add_wen_drop",   32'(rf_wen), 0);
    check("add_pc",         32'(pc), 1);
    check("add_next_req",   32'(imem_req), 1);

    // ---- LDI r5,0xA7 ----
    ticks(2);                                 // EXECUTE
    check("ldi_imm",        32'(imm), 32'h00A7);
    check("ldi_use_imm",    32'(alu_use_imm), 1);
    check("ldi_w1",         32'(rf_w1), 5);
    check("ldi_ex_wen",     32'(rf_wen), 0);
    tick();
    check("ldi_wb_wen",     32'(rf_wen), 1);
    tick();
    check("ldi_wen_drop",   32'(rf_wen), 0);
    check("ldi_next_addr",  32'(imem_addr), 2);

    // ---- ADDI r4,r3,15 ----
    ticks(2);
    check("addi_imm",       32'(imm), 32'h000F);
    check("addi_r1",        32'(rf_r1), 3);
    check("addi_w1",        32'(rf_w1), 4);
    check("addi_use_imm",   32'(alu_use_imm), 1);
    tick();
    check("addi_wb_wen",    32'(rf_wen), 1);
    tick();
    check("addi_next_addr", 32'(imem_addr), 3);

    // ---- NOP : 2 cycles ----
    ticks(2);
    check("nop_next_req",   32'(imem_req), 1);
    check("nop_next_addr",  32'(imem_addr), 4);

    // ---- BEQ at 4, offset -3, taken -> 2 ----
    alu_zero = 1'b1;
    tick();                                   // DECODE
    check("beq_t_dec_wen",  32'(rf_wen), 0);
    tick();                                   // EXECUTE
    check("beq_op",         32'(alu_op), 1);
    check("beq_r1",         32'(rf_r1), 1);
    check("beq_r2",         32'(rf_r2), 2);
    check("beq_t_ex_wen",   32'(rf_wen), 0);
    tick();                                   // FETCH
    check("beq_t_req",      32'(imem_req), 1);
    check("beq_t_addr",     32'(imem_addr), 2);
    check("beq_t_wen",      32'(rf_wen), 0);

    // ADDI (4 cycles) then NOP (2 cycles) back to BEQ at 4
    ticks(4);
    check("loop_addr3",     32'(imem_addr), 3);
    ticks(2);
    check("loop_addr4",     32'(imem_addr), 4);

    // ---- BEQ not taken -> 5 ----
    alu_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("beq_nt_wen", 32'(rf_wen), 0);
    end
    check("beq_nt_req",     32'(imem_req), 1);
    check("beq_nt_addr",    32'(imem_addr), 5);

    // ---- JMP 0xFF : 2 cycles ----
    ticks(2);
    check("jmp_req",        32'(imem_req), 1);
    check("jmp_addr",       32'(imem_addr), 32'hFF);

    // ---- NOP at 0xFF wraps to 0x00 in 2 cycles ----
    ticks(2);
    check("wrap_req",       32'(imem_req), 1);
    check("wrap_addr",      32'(imem_addr), 0);
    check("wrap_pc",        32'(pc), 0);

    // ---- fetch stall: ack low 3 cycles -> FETCH lasts 4 cycles ----
    ack_wait = 3;
    for (int k = 0; k < 4; k++) begin
      check("stall_req",  32'(imem_req), 1);
      check("stall_addr", 32'(imem_addr), 0);
      tick();
    end
    check("stall_dec_req",  32'(imem_req), 0);
    ack_wait = 0;
    tick();                                   // EXECUTE of ADD
    check("stall_add_w1",   32'(rf_w1), 1);
    tick();                                   // WRITEBACK
    check("abort_wb_wen",   32'(rf_wen), 1);

    // ---- reset during WRITEBACK aborts asynchronously ----
    #2;
    reset = 1'b1;
    #1;
    check("abort_wen",      32'(rf_wen), 0);
    check("abort_req",      32'(imem_req), 0);
    check("abort_r2",       32'(rf_r2), 0);
    check("abort_w1",       32'(rf_w1), 0);
    check("abort_r1",       32'(rf_r1), 0);
    check("abort_pc",       32'(pc), 0);
    tick();
    reset = 1'b0;
    ticks(3);
    check("abort_idle_req", 32'(imem_req), 0);
    check("abort_idle_wen", 32'(rf_wen), 0);
    check("abort_idle_pc",  32'(pc), 0);

    // ---- HALT ----
    mem[8'h00] = 16'hF000;
    run = 1'b1;
    tick();                                   // FETCH
    run = 1'b0;
    check("halt_fetch_req", 32'(imem_req), 1);
    tick();                                   // DECODE
    check("halt_dec_flag",  32'(halted), 0);
    tick();                                   // HALT
    check("halt_flag",      32'(halted), 1);
    check("halt_req",       32'(imem_req), 0);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      tick();
      check("halt_hold",     32'(halted), 1);
      check("halt_hold_req", 32'(imem_req), 0);
    end
    check("halt_pc",        32'(pc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_fetch_decode.md
# risc_fetch_decode

Multi-cycle fetch/decode controller for the 16-bit RISC core. It sits directly upstream of the 16×16-bit register file and the ALU. It holds the program counter, fetches 16-bit instructions over a req/ack port, decodes them, and drives register-file read/write addresses, write enable, ALU opcode and immediate. It also resolves branches, jumps and halt.

## Interface
Parameters:
- PC_W, 8, program-counter and instruction-address width

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- run  in  1  leave IDLE and start fetching at PC 0
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle; may coincide with imem_req's first cycle
- imem_rdata  in  16  instruction word, sampled when imem_req && imem_ack
- alu_zero  in  1  ALU result == 0, sampled at end of EXECUTE
- rf_r1, rf_r2  out  4  register-file read addresses (rs1, rs2)
- rf_w1  out  4  register-file write address (rd)
- rf_wen  out  1  register-file write enable
- alu_op  out  4  opcode passed to ALU
- alu_use_imm  out  1  ALU operand B is imm rather than read port 2
- imm  out  16  extended immediate
- pc  out  PC_W  current PC (observability)
- halted  out  1  HALT executed

## Operation
- Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR: rd ← rs1 op rs2.
  - 7 ADDI: rd ← rs1 + zext(imm4).
  - 8 LDI: rd ← zext([7:0]).
  - 9 BEQ: if rs1 == rs2 then pc ← pc + 1 + sext([11:8]); the ALU is issued SUB, and alu_zero is the decision.
  - A JMP: pc ← [PC_W-1:0].
  - B–E NOP.
  - F HALT.
- States:
  - IDLE: run=1 → FETCH.
  - FETCH: imem_req=1; on imem_ack, latch the instruction → DECODE; otherwise stay.
  - DECODE: drive the address and control outputs.
    - ALU/ADDI/LDI → EXECUTE.
    - BEQ → EXECUTE.
    - JMP: load pc → FETCH.
    - NOP: pc+1 → FETCH.
    - HALT → HALT.
  - EXECUTE: ALU result settles.
    - Writing ops → WRITEBACK.
    - BEQ: update pc per alu_zero → FETCH.
  - WRITEBACK: rf_wen=1 for exactly this cycle; pc+1 → FETCH.
  - HALT: halted=1, stays until reset; run ignored.
- rf_r1/rf_r2/rf_w1/alu_op/alu_use_imm/imm are registered in DECODE and held stable until the next DECODE.
- rf_wen is never high outside WRITEBACK.
- All PC arithmetic is modulo 2^PC_W:
  - pc = 2^PC_W−1 increments to 0.
  - Branch offsets are signed 4-bit (−8..+7) and wrap.
- imem_ack outside FETCH is ignored.

## Timing
- Reset values: pc=0, state IDLE, imem_req=0, imem_addr=0, rf_r1=rf_r2=rf_w1=0, rf_wen=0, alu_op=0, alu_use_imm=0, imm=0, halted=0.
- Reset asserted mid-instruction aborts immediately:
  - A WRITEBACK in progress does not complete; rf_wen drops asynchronously.
  - After release, the block waits in IDLE for run.
- Zero-wait fetch (ack in the first FETCH cycle):
  - Writing ops take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - BEQ takes 3 cycles.
  - JMP and NOP take 2 cycles.
- Each cycle of imem_ack low extends FETCH by one cycle.
- imem_addr is stable for the whole of FETCH.

## Structure
- Shared package risc_pkg holds:
  - opcode constants;
  - state encoding;
  - instruction field bit positions;
  - the ALU opcode type, shared with the ALU.
- One sub-module, risc_instr_decoder: purely combinational opcode → {writes_rd, use_imm, imm_sel, is_branch, is_jump, is_halt}.
- The FSM, pc register and output registers live in risc_fetch_decode.

## Test plan
- Reset, run=1, imem returns 0x0123 (ADD r1,r2,r3) with ack immediate → rf_r1=2, rf_r2=3, rf_w1=1, alu_op=0; rf_wen high exactly one cycle, 4 cycles after FETCH entry; pc becomes 1.
- LDI r5,0xA7 (0x85A7) → imm=0x00A7, alu_use_imm=1, rf_w1=5, one rf_wen pulse. ADDI (0x7_4_3_F) → imm=0x000F.
- BEQ at pc=4, offset −3 (0x9D12):
  - alu_zero=1 → next imem_addr=2;
  - alu_zero=0 → next imem_addr=5;
  - no rf_wen in either case.
- JMP 0xFF then NOP → fetches at 0xFF, then 0x00 (wrap); the NOP at 0xFF completes in 2 cycles.
- imem_ack held low 3 cycles → imem_req and imem_addr stable for 4 cycles; decode occurs only after ack.
- HALT (0xF000) → halted=1, imem_req stays 0, run toggling ignored. Reset asserted during WRITEBACK → rf_wen falls immediately, all outputs return to reset values, block sits in IDLE.
